// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states,
// instruction fields, datapath select codes and exception causes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    ADDIEX,
    ADDIWB,
    BRANCH,
    JUMP,
    JR,
    EXC
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] PC_SEL_ALU     = 3'd0;
  localparam logic [2:0] PC_SEL_ALU_REG = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP    = 3'd2;
  localparam logic [2:0] PC_SEL_REG1    = 3'd3;
  localparam logic [2:0] PC_SEL_VEC0    = 3'd4;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic CAUSE_UNDEF = 1'b0;
  localparam logic CAUSE_OVF   = 1'b1;

  // Only add and sub trap on signed overflow; slt/and/or ignore the flag.
  function automatic logic is_addsub(input logic [2:0] ctl);
    return (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the control-level ALU operation (add / sub / by funct) to the
// 3-bit ALU control code and flags funct values the ALU does not implement.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6
) (
  input  alu_op_t                ALUOp,
  input  logic [FUNCT_WIDTH-1:0] Funct,
  output logic [2:0]             ALUControl,
  output logic                   funct_valid
);

  always_comb begin
    ALUControl  = ALU_ADD;
    funct_valid = 1'b1;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (Funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: funct_valid = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multi-cycle main control FSM: sequences fetch, decode, execute, memory and
// write-back steps and vectors undefined-opcode / overflow exceptions to 0.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic [FUNCT_WIDTH-1:0]  Funct,
  input  logic                    Zero,
  input  logic                    Overflow,
  input  logic                    MEM_RDY,
  output logic                    PC_LOAD,
  output logic                    IorD,
  output logic                    IR_EN,
  output logic                    EPC_EN,
  output logic [2:0]              PC_SEL,
  output logic                    MEM_REQ,
  output logic                    MemWrite,
  output logic                    RegWrite,
  output logic                    RegDst,
  output logic                    MemtoReg,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [2:0]              ALUControl,
  output logic                    Cause_EN,
  output logic                    Cause,
  output state_t                  dbg_state
);

  // Memory handshake: MEM_REQ is held high for the whole access; the access
  // completes in the cycle MEM_RDY is high, and only then do IR_EN, PC_LOAD
  // (fetch) and MemWrite (store) fire and the FSM leave the memory state.

  state_t  state;
  state_t  state_nxt;
  logic    cause_q;
  logic    cause_nxt;
  alu_op_t alu_op;
  logic    funct_valid;

  alu_decoder #(
    .FUNCT_WIDTH(FUNCT_WIDTH)
  ) u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .funct_valid(funct_valid)
  );

  always_comb begin
    state_nxt = FETCH;
    cause_nxt = cause_q;
    case (state)
      FETCH:   state_nxt = MEM_RDY ? DECODE : FETCH;
      DECODE: begin
        if (Opcode == OP_LW || Opcode == OP_SW) begin
          state_nxt = MEMADR;
        end else if (Opcode == OP_RTYPE) begin
          state_nxt = (Funct == FN_JR) ? JR : EXECUTE;
        end else if (Opcode == OP_BEQ || Opcode == OP_BNE) begin
          state_nxt = BRANCH;
        end else if (Opcode == OP_ADDI) begin
          state_nxt = ADDIEX;
        end else if (Opcode == OP_J) begin
          state_nxt = JUMP;
        end else begin
          state_nxt = EXC;
          cause_nxt = CAUSE_UNDEF;
        end
      end
      MEMADR:  state_nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_nxt = MEM_RDY ? MEMWB : MEMRD;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   state_nxt = MEM_RDY ? FETCH : MEMWR;
      EXECUTE: begin
        if (!funct_valid) begin
          state_nxt = EXC;
          cause_nxt = CAUSE_UNDEF;
        end else if (Overflow && is_addsub(ALUControl)) begin
          state_nxt = EXC;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = ALUWB;
        end
      end
      ALUWB:   state_nxt = FETCH;
      ADDIEX: begin
        if (Overflow) begin
          state_nxt = EXC;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = ADDIWB;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= FETCH;
      cause_q <= CAUSE_UNDEF;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  always_comb begin
    PC_LOAD  = 1'b0;
    IorD     = 1'b0;
    IR_EN    = 1'b0;
    EPC_EN   = 1'b0;
    PC_SEL   = PC_SEL_ALU;
    MEM_REQ  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    alu_op   = ALUOP_ADD;
    Cause_EN = 1'b0;
    case (state)
      FETCH: begin
        MEM_REQ = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IR_EN   = MEM_RDY;
        PC_LOAD = MEM_RDY;
      end
      // Branch target is precomputed here and parked in the ALU register.
      DECODE:  ALUSrcB = SRCB_IMM_SH2;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MEM_REQ = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MEM_REQ  = 1'b1;
        IorD     = 1'b1;
        MemWrite = MEM_RDY;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ADDIWB:  RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PC_SEL  = PC_SEL_ALU_REG;
        PC_LOAD = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      JUMP: begin
        PC_SEL  = PC_SEL_JUMP;
        PC_LOAD = 1'b1;
      end
      JR: begin
        PC_SEL  = PC_SEL_REG1;
        PC_LOAD = 1'b1;
      end
      EXC: begin
        EPC_EN   = 1'b1;
        Cause_EN = 1'b1;
        PC_SEL   = PC_SEL_VEC0;
        PC_LOAD  = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides every write enable so nothing commits on the reset edge.
    if (!RST) begin
      PC_LOAD  = 1'b0;
      IR_EN    = 1'b0;
      EPC_EN   = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Cause_EN = 1'b0;
      MEM_REQ  = 1'b0;
    end
  end

  assign Cause     = cause_q;
  assign dbg_state = state;

endmodule
